// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter: requests, write data,
// flush, grant, and the read-back of the shared register.
interface shared_reg_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic           flush;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  owner;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           wr_ack;

    modport master (
        output flush, req, wdata,
        input  gnt, owner, q, q_valid, wr_ack
    );

    modport slave (
        input  flush, req, wdata,
        output gnt, owner, q, q_valid, wr_ack
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters, with tenure
// bounded to MAX_HOLD writes so a busy requester cannot starve the others.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate from rr_ptr on any request
// OWN   | owner holds the grant; writes while req stays high, releases on drop or hold limit
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_reg_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   q_q, q_d;
    logic           q_valid_q, q_valid_d;
    logic           wr_ack_q, wr_ack_d;

    logic [IW:0]    arb_res;
    logic [IW-1:0]  rel_ptr;
    logic [W-1:0]   wsel;
    logic           own_req;
    logic           release_now;

    // {found, index} of the first set request searching upward from ptr, wrapping.
    function automatic logic [IW:0] arb_pick(input logic [N-1:0] r, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (r[IW'(idx)]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        wsel    = '0;
        own_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                wsel    = bus.wdata[i*W +: W];
                own_req = bus.req[i];
            end
        end
        rel_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        q_d         = q_q;
        q_valid_d   = q_valid_q;
        wr_ack_d    = 1'b0;
        arb_res     = '0;
        release_now = 1'b0;

        if (bus.flush) begin
            state_d    = IDLE;
            owner_d    = '0;
            hold_cnt_d = '0;
            gnt_d      = '0;
            q_d        = '0;
            q_valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    arb_res = arb_pick(bus.req, rr_ptr_q);
                    if (arb_res[IW]) begin
                        state_d    = OWN;
                        owner_d    = arb_res[IW-1:0];
                        gnt_d      = N'(1) << arb_res[IW-1:0];
                        hold_cnt_d = '0;
                    end
                end
                OWN: begin
                    if (own_req) begin
                        q_d        = wsel;
                        q_valid_d  = 1'b1;
                        wr_ack_d   = 1'b1;
                        hold_cnt_d = hold_cnt_q + 8'd1;
                        if (hold_cnt_q == 8'(MAX_HOLD - 1)) release_now = 1'b1;
                    end else begin
                        release_now = 1'b1;
                    end

                    // Handoff happens at the releasing edge so there is no idle bubble.
                    if (release_now) begin
                        rr_ptr_d = rel_ptr;
                        arb_res  = arb_pick(bus.req, rel_ptr);
                        if (arb_res[IW]) begin
                            owner_d    = arb_res[IW-1:0];
                            gnt_d      = N'(1) << arb_res[IW-1:0];
                            hold_cnt_d = '0;
                        end else begin
                            state_d    = IDLE;
                            owner_d    = '0;
                            gnt_d      = '0;
                            hold_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.wr_ack  = wr_ack_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomised and directed bench for shared_reg_arbiter against a behavioural model
// of round-robin tenure, hold limit, flush and reset.
module tb_shared_reg_arbiter;
    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

    shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit        m_busy;
    int        m_owner;
    int        m_ptr;
    int        m_cnt;
    int        m_q;
    bit        m_qv;
    bit        m_ack;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = 0; m_qv = 0; m_ack = 0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input bit f, input logic [N-1:0] r, input logic [N*W-1:0] wd);
        int w;
        m_ack = 0;
        if (f) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_q = 0; m_qv = 0;
            return;
        end
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 0;
            end
        end else begin
            bit give_up;
            give_up = 0;
            if (((r >> m_owner) & 1) != 0) begin
                m_q   = int'((wd >> (m_owner * W)) & 32'hFF);
                m_qv  = 1;
                m_ack = 1;
                m_cnt = m_cnt + 1;
                if (m_cnt == MAX_HOLD) give_up = 1;
            end else begin
                give_up = 1;
            end
            if (give_up) begin
                m_ptr = (m_owner + 1) % N;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_cnt = 0;
                end else begin
                    m_busy = 0; m_owner = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] exp_g;
        int gi;
        exp_g = m_busy ? (N'(1) << m_owner) : '0;
        chk_eq({tag, ".gnt"},     32'(bus.gnt),     32'(exp_g));
        chk_eq({tag, ".owner"},   32'(bus.owner),   32'(m_owner));
        chk_eq({tag, ".q"},       32'(bus.q),       32'(m_q));
        chk_eq({tag, ".q_valid"}, 32'(bus.q_valid), 32'(m_qv));
        chk_eq({tag, ".wr_ack"},  32'(bus.wr_ack),  32'(m_ack));
        chk_eq({tag, ".onehot0"}, 32'($onehot0(bus.gnt)), 32'd1);
        gi = 0;
        for (int i = 0; i < N; i++) if (bus.gnt[i]) gi = i;
        chk_eq({tag, ".owner_idx"}, 32'(bus.owner), 32'(gi));
    endtask

    task automatic cycle(input string tag, input bit f, input logic [N-1:0] r, input logic [N*W-1:0] wd);
        bus.flush = f;
        bus.req   = r;
        bus.wdata = wd;
        @(posedge clk);
        model_step(f, r, wd);
        #1;
        compare_all(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, ".gnt"},     32'(bus.gnt),     32'd0);
        chk_eq({tag, ".owner"},   32'(bus.owner),   32'd0);
        chk_eq({tag, ".q"},       32'(bus.q),       32'd0);
        chk_eq({tag, ".q_valid"}, 32'(bus.q_valid), 32'd0);
        chk_eq({tag, ".wr_ack"},  32'(bus.wr_ack),  32'd0);
    endtask

    logic [N*W-1:0] wd_rot;
    logic [N-1:0]   rnd_req;
    logic [N*W-1:0] rnd_wd;

    initial begin
        rst       = 1'b0;
        bus.flush = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;
        model_reset();

        // reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        repeat (5) cycle("idle", 1'b0, 4'b0000, '0);

        // single requester, three writes then drop
        cycle("single_gnt", 1'b0, 4'b0001, 32'h0000_0011);
        chk_eq("single_gnt_now", 32'(bus.gnt), 32'h1);
        chk_eq("single_no_ack_on_grant", 32'(bus.wr_ack), 32'd0);
        cycle("single_w1", 1'b0, 4'b0001, 32'h0000_0011);
        chk_eq("single_q1", 32'(bus.q), 32'h11);
        cycle("single_w2", 1'b0, 4'b0001, 32'h0000_0022);
        chk_eq("single_q2", 32'(bus.q), 32'h22);
        cycle("single_w3", 1'b0, 4'b0001, 32'h0000_0033);
        chk_eq("single_q3", 32'(bus.q), 32'h33);
        cycle("single_drop", 1'b0, 4'b0000, 32'h0000_00EE);
        chk_eq("single_drop_gnt", 32'(bus.gnt), 32'd0);
        chk_eq("single_hold_q", 32'(bus.q), 32'h33);
        chk_eq("single_hold_qv", 32'(bus.q_valid), 32'd1);
        repeat (2) cycle("single_idle", 1'b0, 4'b0000, 32'h0000_0099);

        // hold-limit rotation with all requesters busy
        wd_rot = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (24) cycle("rotate", 1'b0, 4'b1111, wd_rot);
        cycle("rotate_end", 1'b0, 4'b0000, wd_rot);

        // sole requester regranted at the limit
        for (int i = 0; i < 11; i++) begin
            rnd_wd = 32'($urandom);
            cycle("sole", 1'b0, 4'b0100, rnd_wd);
        end
        chk_eq("sole_gnt_held", 32'(bus.gnt), 32'h4);
        cycle("sole_end", 1'b0, 4'b0000, '0);

        // drop handoff from requester 1 to requester 2
        cycle("handoff_gnt", 1'b0, 4'b0110, 32'h0033_2200);
        cycle("handoff_w1", 1'b0, 4'b0110, 32'h0034_2300);
        cycle("handoff_drop", 1'b0, 4'b0100, 32'h0035_2400);
        chk_eq("handoff_gnt_moved", 32'(bus.gnt), 32'h4);
        chk_eq("handoff_no_ack", 32'(bus.wr_ack), 32'd0);
        chk_eq("handoff_q_kept", 32'(bus.q), 32'h23);
        cycle("handoff_w2", 1'b0, 4'b0100, 32'h0036_2500);
        cycle("handoff_end", 1'b0, 4'b0000, '0);

        // flush during a write by requester 3
        cycle("flush_gnt", 1'b0, 4'b1000, 32'h7100_0000);
        cycle("flush_w1", 1'b0, 4'b1000, 32'h7200_0000);
        cycle("flush_edge", 1'b1, 4'b1000, 32'h7300_0000);
        check_all_zero("flush_clear");
        repeat (6) cycle("flush_after", 1'b0, 4'b1001, 32'h7400_0055);

        // async reset between edges, mid-tenure
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("async_rst_held");
        rst = 1'b1;
        cycle("post_rst_gnt", 1'b0, 4'b1111, 32'hD3D2_D1D0);
        chk_eq("post_rst_owner0", 32'(bus.owner), 32'd0);
        repeat (5) cycle("post_rst", 1'b0, 4'b1111, 32'hD3D2_D1D0);

        // randomised traffic
        rnd_req = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = N'($urandom_range(0, 15));
            rnd_wd = 32'($urandom);
            cycle("rand", ($urandom_range(0, 39) == 0), rnd_req, rnd_wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
